al_accel_pool: RTL and testbench
================================

AL_ACCEL_POOL -- requirements
Module: al_accel_pool

Interface
REQ-001 Parameter DW, default 8: signed data width of pool_di, pool_do and each buffer entry.
REQ-002 Parameter NBUF, default 13: number of max-pool buffer entries, indexed 0..NBUF-1.
REQ-003 clk  input  1: single clock; all state updates on the rising edge.
REQ-004 resetn  input  1: reset, asynchronous and active-low.
REQ-005 pool_di  input  DW signed: pixel from the conv/activation stage.
REQ-006 sel_demux  input  4: write-select, the buffer entry updated this cycle.
REQ-007 sel_mux  input  4: read-select, the buffer entry driven on pool_do.
REQ-008 mpbuf_ld_wrn  input  1: 1 = load/accumulate mode (compare with stored value); 0 = write mode (overwrite).
REQ-009 cp_enb  input  1: comparator enable; effective only when mpbuf_ld_wrn=1.
REQ-010 enb  input  1: block enable; when 0, no buffer entry changes.
REQ-011 pool_do  output  DW signed: pooled result read from the buffer.

Function
REQ-012 Storage: NBUF registers mpbuf[0..NBUF-1], each DW bits, two's complement.
REQ-013 Update condition: an entry is written on a rising clk edge only when enb=1 and sel_demux<NBUF; at most one entry changes per cycle.
REQ-014 sel_demux>=NBUF (13..15 by default) with enb=1: no entry changes and no error is flagged.
REQ-015 Written value when mpbuf_ld_wrn=1 and cp_enb=1: the signed maximum of mpbuf[sel_demux] and pool_di. Equal values leave the entry unchanged.
REQ-016 Written value when mpbuf_ld_wrn=0, or when cp_enb=0: pool_di, overwriting the entry. Write mode starts a new pooling window.
REQ-017 Comparison is signed, so -128 is less than 0 and 127 is the maximum; no saturation or width growth occurs.
REQ-018 Write latency: an input presented before rising edge N is visible on pool_do after edge N when sel_mux equals the written index.
REQ-019 pool_do is combinational: pool_do = mpbuf[sel_mux] for sel_mux<NBUF, and 0 for sel_mux>=NBUF.
REQ-020 Same-cycle read and write of one index: pool_do shows the old value until the edge, then the new value.
REQ-021 Entries not selected by sel_demux hold their value indefinitely.
REQ-022 No handshake: the upstream controller sequences sel_demux and mode; the block accepts one sample per enabled cycle.

Reset
REQ-023 resetn=0 immediately clears all mpbuf entries to 0, independent of clk; pool_do therefore reads 0.
REQ-024 Reset asserted mid-accumulation discards all partial maxima; the first enabled edge after deassertion updates the buffer normally.
REQ-025 While resetn=0, enb, cp_enb and sel inputs are ignored.

Verification
REQ-026 Reset, then set sel_mux 0..12 with no writes -> pool_do=0 for every index.
REQ-027 Accumulate: ld_wrn=1, cp_enb=1, enb=1, sel_demux=3, pool_di=36 then 99 -> sel_mux=3 gives 99. Then pool_di=-5 -> entry stays 99.
REQ-028 Negative window: ld_wrn=0 with pool_di=-20 into entry 5, then ld_wrn=1, cp_enb=1 with pool_di=-7 -> pool_do(sel_mux=5)=-7. From reset, load-only -20 then -7 -> pool_do=0.
REQ-029 Full sweep: two random samples per sel_demux 0..12 in load mode from reset -> each pool_do equals max(0, s0, s1); sel_mux=13..15 -> 0.
REQ-030 Gating: enb=0 with any pool_di and sel -> buffer unchanged. sel_demux=14 with enb=1 -> all entries unchanged.
REQ-031 Async reset mid-stream: pull resetn low between clock edges -> pool_do drops to 0 with no clock edge; a later write to entry 0 of 12 -> pool_do(0)=12.

Source files
------------

// File: rtl/al_accel_pool.sv
// Max-pool buffer: NBUF signed entries. Each enabled cycle one entry, chosen by
// sel_demux, is either overwritten with pool_di (starting a new pooling window)
// or replaced by the signed max of itself and pool_di (accumulating the window).
// The entry chosen by sel_mux is driven combinationally on pool_do.
module al_accel_pool #(
   parameter int DW   = 8,
   parameter int NBUF = 13
) (
   input  logic                 clk,
   input  logic                 resetn,
   input  logic signed [DW-1:0] pool_di,
   input  logic [3:0]           sel_demux,
   input  logic [3:0]           sel_mux,
   input  logic                 mpbuf_ld_wrn,
   input  logic                 cp_enb,
   input  logic                 enb,
   output logic signed [DW-1:0] pool_do
);

   logic signed [DW-1:0] mpbuf [NBUF];
   logic                 cmp_mode;

   // Comparator only matters in load mode; otherwise every write overwrites.
   assign cmp_mode = mpbuf_ld_wrn & cp_enb;

   // Buffer update: at most one entry per edge. Out-of-range selects match no
   // entry and are silently dropped. Keeping the stored value on a tie or when
   // it is larger gives the signed maximum without a separate mux.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         for (int i = 0; i < NBUF; i++) begin
            mpbuf[i] <= '0;
         end
      end else if (enb) begin
         for (int i = 0; i < NBUF; i++) begin
            if (sel_demux == 4'(i)) begin
               if (!(cmp_mode && (mpbuf[i] >= pool_di))) begin
                  mpbuf[i] <= pool_di;
               end
            end
         end
      end
   end

   // Read mux: unimplemented indices read as zero.
   always_comb begin
      pool_do = '0;
      for (int i = 0; i < NBUF; i++) begin
         if (sel_mux == 4'(i)) begin
            pool_do = mpbuf[i];
         end
      end
   end

endmodule

// File: tb/tb_al_accel_pool.sv
// Self-checking bench for al_accel_pool with a behavioural buffer model.
module tb_al_accel_pool;

   localparam int NBUF = 13;

   logic              clk;
   logic              resetn;
   logic signed [7:0] pool_di;
   logic [3:0]        sel_demux;
   logic [3:0]        sel_mux;
   logic              mpbuf_ld_wrn;
   logic              cp_enb;
   logic              enb;
   logic signed [7:0] pool_do;

   // Model: one signed value per select code; codes >= NBUF always read 0.
   int ref_buf [16];
   int errors = 0;
   int checks = 0;

   al_accel_pool #(.DW(8), .NBUF(NBUF)) dut (
      .clk          (clk),
      .resetn       (resetn),
      .pool_di      (pool_di),
      .sel_demux    (sel_demux),
      .sel_mux      (sel_mux),
      .mpbuf_ld_wrn (mpbuf_ld_wrn),
      .cp_enb       (cp_enb),
      .enb          (enb),
      .pool_do      (pool_do)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached, got running, required finished");
      $fatal(1, "watchdog");
   end

   // Apply one sample across a rising edge and update the model by the rules:
   // write when enabled and in range; max if load+compare, else overwrite.
   task automatic apply(input logic en, input logic ldwrn, input logic cp,
                        input logic [3:0] sel, input int di);
      enb          = en;
      mpbuf_ld_wrn = ldwrn;
      cp_enb       = cp;
      sel_demux    = sel;
      pool_di      = 8'(di);
      @(posedge clk);
      #1;
      if (en && sel < NBUF) begin
         if (ldwrn && cp) begin
            if (di > ref_buf[sel]) ref_buf[sel] = di;
         end else begin
            ref_buf[sel] = di;
         end
      end
      enb = 1'b0;
   endtask

   task automatic do_reset();
      @(negedge clk);
      resetn = 1'b0;
      #2;
      resetn = 1'b1;
      for (int i = 0; i < 16; i++) ref_buf[i] = 0;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      // inputs active while held in reset must be ignored
      @(negedge clk);
      resetn = 1'b0;
      enb = 1'b1; mpbuf_ld_wrn = 1'b0; cp_enb = 1'b0; sel_demux = 4'd2; pool_di = 8'sd50;
      @(posedge clk);
      #1;
      sel_mux = 4'd2;
      #1;
      checks++;
      if (pool_do !== 8'sd0) begin
         errors++;
         $display("FAIL reset_hold_ignore: got %0d, required 0", pool_do);
      end
      enb = 1'b0;
      resetn = 1'b1;
      for (int i = 0; i < 16; i++) ref_buf[i] = 0;
      @(posedge clk);
      #1;
      for (int s = 0; s < NBUF; s++) begin
         sel_mux = 4'(s);
         #1;
         checks++;
         if (pool_do !== 8'sd0) begin
            errors++;
            $display("FAIL reset_zero[%0d]: got %0d, required 0", s, pool_do);
         end
      end
   endtask

   task automatic test_accumulate();
      do_reset();
      sel_mux = 4'd3;
      apply(1'b1, 1'b1, 1'b1, 4'd3, 36);
      apply(1'b1, 1'b1, 1'b1, 4'd3, 99);
      checks++;
      if (pool_do !== 8'sd99) begin
         errors++;
         $display("FAIL accumulate_max: got %0d, required 99", pool_do);
      end
      apply(1'b1, 1'b1, 1'b1, 4'd3, -5);
      checks++;
      if (pool_do !== 8'sd99) begin
         errors++;
         $display("FAIL accumulate_keep: got %0d, required 99", pool_do);
      end
      // tie leaves entry unchanged; compare disabled overwrites
      apply(1'b1, 1'b1, 1'b1, 4'd3, 99);
      apply(1'b1, 1'b1, 1'b0, 4'd3, -128);
      checks++;
      if (pool_do !== -8'sd128) begin
         errors++;
         $display("FAIL cp_off_overwrite: got %0d, required -128", pool_do);
      end
      apply(1'b1, 1'b1, 1'b1, 4'd3, 127);
      checks++;
      if (pool_do !== 8'sd127) begin
         errors++;
         $display("FAIL signed_extreme: got %0d, required 127", pool_do);
      end
   endtask

   task automatic test_negative_window();
      do_reset();
      sel_mux = 4'd5;
      apply(1'b1, 1'b0, 1'b1, 4'd5, -20);
      checks++;
      if (pool_do !== -8'sd20) begin
         errors++;
         $display("FAIL neg_write: got %0d, required -20", pool_do);
      end
      apply(1'b1, 1'b1, 1'b1, 4'd5, -7);
      checks++;
      if (pool_do !== -8'sd7) begin
         errors++;
         $display("FAIL neg_window_max: got %0d, required -7", pool_do);
      end
      do_reset();
      sel_mux = 4'd5;
      apply(1'b1, 1'b1, 1'b1, 4'd5, -20);
      apply(1'b1, 1'b1, 1'b1, 4'd5, -7);
      checks++;
      if (pool_do !== 8'sd0) begin
         errors++;
         $display("FAIL neg_load_from_reset: got %0d, required 0", pool_do);
      end
   endtask

   task automatic test_full_sweep();
      int s0, s1, exp_v;
      do_reset();
      for (int s = 0; s < NBUF; s++) begin
         s0 = int'($urandom_range(0, 255)) - 128;
         s1 = int'($urandom_range(0, 255)) - 128;
         apply(1'b1, 1'b1, 1'b1, 4'(s), s0);
         apply(1'b1, 1'b1, 1'b1, 4'(s), s1);
         exp_v = 0;
         if (s0 > exp_v) exp_v = s0;
         if (s1 > exp_v) exp_v = s1;
         sel_mux = 4'(s);
         #1;
         checks++;
         if (int'(pool_do) !== exp_v) begin
            errors++;
            $display("FAIL sweep[%0d]: got %0d, required %0d (s0=%0d s1=%0d)", s, pool_do, exp_v, s0, s1);
         end
      end
      for (int s = NBUF; s < 16; s++) begin
         sel_mux = 4'(s);
         #1;
         checks++;
         if (pool_do !== 8'sd0) begin
            errors++;
            $display("FAIL sweep_oob[%0d]: got %0d, required 0", s, pool_do);
         end
      end
   endtask

   task automatic test_gating();
      int bad;
      for (int k = 0; k < 8; k++) begin
         apply(1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
               4'($urandom_range(0, 12)), int'($urandom_range(0, 255)) - 128);
      end
      for (int k = 0; k < 4; k++) begin
         apply(1'b1, 1'b0, 1'b0, 4'd14, int'($urandom_range(0, 255)) - 128);
      end
      apply(1'b1, 1'b0, 1'b0, 4'd13, 77);
      apply(1'b1, 1'b0, 1'b0, 4'd15, 77);
      bad = 0;
      for (int s = 0; s < 16; s++) begin
         sel_mux = 4'(s);
         #1;
         if (int'(pool_do) !== ref_buf[s]) begin
            bad++;
            $display("FAIL gating[%0d]: got %0d, required %0d", s, pool_do, ref_buf[s]);
         end
      end
      checks++;
      if (bad != 0) errors++;
   endtask

   task automatic test_same_cycle();
      sel_mux      = 4'd7;
      enb          = 1'b1;
      mpbuf_ld_wrn = 1'b0;
      cp_enb       = 1'b0;
      sel_demux    = 4'd7;
      pool_di      = 8'sd55;
      if (ref_buf[7] == 55) pool_di = 8'sd56;
      #1;
      checks++;
      if (int'(pool_do) !== ref_buf[7]) begin
         errors++;
         $display("FAIL same_cycle_old: got %0d, required %0d", pool_do, ref_buf[7]);
      end
      @(posedge clk);
      #1;
      ref_buf[7] = int'(pool_di);
      enb = 1'b0;
      checks++;
      if (int'(pool_do) !== ref_buf[7]) begin
         errors++;
         $display("FAIL same_cycle_new: got %0d, required %0d", pool_do, ref_buf[7]);
      end
   endtask

   task automatic test_random_mix();
      for (int k = 0; k < 300; k++) begin
         apply(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 3) != 0),
               1'($urandom_range(0, 3) != 0), 4'($urandom_range(0, 15)),
               int'($urandom_range(0, 255)) - 128);
         sel_mux = 4'($urandom_range(0, 15));
         #1;
         checks++;
         if (int'(pool_do) !== ref_buf[sel_mux]) begin
            errors++;
            $display("FAIL random[%0d] sel_mux=%0d: got %0d, required %0d", k, sel_mux, pool_do, ref_buf[sel_mux]);
         end
      end
   endtask

   task automatic test_async_reset();
      apply(1'b1, 1'b0, 1'b0, 4'd0, 88);
      apply(1'b1, 1'b1, 1'b1, 4'd9, 100);
      sel_mux = 4'd9;
      @(negedge clk);
      #2;
      resetn = 1'b0;
      #1;
      checks++;
      if (pool_do !== 8'sd0) begin
         errors++;
         $display("FAIL async_reset_drop: got %0d, required 0", pool_do);
      end
      for (int i = 0; i < 16; i++) ref_buf[i] = 0;
      #1;
      resetn = 1'b1;
      @(posedge clk);
      #1;
      sel_mux = 4'd0;
      apply(1'b1, 1'b1, 1'b1, 4'd0, 12);
      checks++;
      if (pool_do !== 8'sd12) begin
         errors++;
         $display("FAIL async_reset_rewrite: got %0d, required 12", pool_do);
      end
   endtask

   initial begin
      resetn       = 1'b0;
      enb          = 1'b0;
      mpbuf_ld_wrn = 1'b0;
      cp_enb       = 1'b0;
      sel_demux    = 4'd0;
      sel_mux      = 4'd0;
      pool_di      = 8'sd0;
      for (int i = 0; i < 16; i++) ref_buf[i] = 0;
      @(posedge clk);
      #1;
      test_reset();
      test_accumulate();
      test_negative_window();
      test_full_sweep();
      test_gating();
      test_same_cycle();
      test_random_mix();
      test_async_reset();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
